// File: rtl/output_deserializer.sv
// output_deserializer
//   Packs a serial stream of words (valid/ready in) into a parallel vector
//   (valid/ack out). Word k lands at parallelOut[(k+1)*dataWidth-1 -: dataWidth],
//   matching the slice order of the downstream serializer.
//   Optional feature macro: DESER_INDEX_CHECK_EN adds inIndex/indexError, a
//   sticky flag raised when the sender's index disagrees with the write slot.
//
//   state   | meaning
//   COLLECT | accepting words, inReady high
//   FULL    | vector complete, outValid high, waiting for outAck
module output_deserializer #(
    parameter int numOutputs   = 16,
    parameter int dataWidth    = 16,
    parameter int counterWidth = (numOutputs > 1) ? $clog2(numOutputs) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              inValid,
    input  logic [dataWidth-1:0]              inData,
    output logic                              inReady,
    output logic [counterWidth-1:0]           counterOut,
    output logic [dataWidth*numOutputs-1:0]   parallelOut,
    input  logic                              outAck,
`ifdef DESER_INDEX_CHECK_EN
    input  logic [counterWidth-1:0]           inIndex,
    output logic                              indexError,
`endif
    output logic                              outValid
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    localparam logic [counterWidth-1:0] lastSlot = counterWidth'(numOutputs - 1);

    state_t state;

    // Ready depends on state only, so the sender never sees a combinational path from inValid.
    assign inReady = (state == COLLECT);

    // Sequencing: reset beats clear, clear beats accept/ack; parallelOut survives clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            counterOut  <= '0;
            outValid    <= 1'b0;
            parallelOut <= '0;
`ifdef DESER_INDEX_CHECK_EN
            indexError  <= 1'b0;
`endif
        end else if (clear) begin
            state      <= COLLECT;
            counterOut <= '0;
            outValid   <= 1'b0;
`ifdef DESER_INDEX_CHECK_EN
            indexError <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (inValid) begin
                        parallelOut[int'(counterOut)*dataWidth +: dataWidth] <= inData;
`ifdef DESER_INDEX_CHECK_EN
                        if (inIndex != counterOut) begin
                            indexError <= 1'b1;
                        end
`endif
                        if (counterOut == lastSlot) begin
                            counterOut <= '0;
                            state      <= FULL;
                            outValid   <= 1'b1;
                        end else begin
                            counterOut <= counterOut + counterWidth'(1);
                        end
                    end
                end
                FULL: begin
                    // Words offered while full are ignored; ack reopens collection.
                    if (outAck) begin
                        state    <= COLLECT;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_deserializer.sv
// tb_output_deserializer
//   Table-driven per-cycle checks on a 4x8 instance, a queue scoreboard for
//   randomised back-to-back vectors, hand sequences for reset/clear corner
//   cases, the optional index check, and a 1-word instance.
module tb_output_deserializer;

    logic        clk = 1'b0;
    logic        reset, clear, inValid, outAck;
    logic [7:0]  inData;
    logic        inReady, outValid;
    logic [1:0]  counterOut;
    logic [31:0] parallelOut;
    logic [1:0]  inIndex;
    logic        indexError;

    logic        s_clear, s_valid, s_ack, s_ready, s_ovalid;
    logic [7:0]  s_data, s_par;
    logic [0:0]  s_cnt;
    logic        s_err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    output_deserializer #(.numOutputs(4), .dataWidth(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .inValid(inValid), .inData(inData),
        .inReady(inReady), .counterOut(counterOut), .parallelOut(parallelOut),
        .outAck(outAck),
`ifdef DESER_INDEX_CHECK_EN
        .inIndex(inIndex), .indexError(indexError),
`endif
        .outValid(outValid)
    );

    output_deserializer #(.numOutputs(1), .dataWidth(8)) dut1 (
        .clk(clk), .reset(reset), .clear(s_clear), .inValid(s_valid), .inData(s_data),
        .inReady(s_ready), .counterOut(s_cnt), .parallelOut(s_par),
        .outAck(s_ack),
`ifdef DESER_INDEX_CHECK_EN
        .inIndex(1'b0), .indexError(s_err),
`endif
        .outValid(s_ovalid)
    );

`ifndef DESER_INDEX_CHECK_EN
    assign indexError = 1'b0;
    assign s_err = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        clr;
        logic        ack;
        logic        ev;
        logic        er;
        logic [1:0]  ec;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] sb_q[$];
    logic        sb_en = 1'b0;
    logic        ov_q = 1'b0;

    function automatic vec_t mk(logic v, logic [7:0] d, logic clr, logic ack,
                                logic ev, logic er, logic [1:0] ec, logic [31:0] ep);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.ack = ack;
        r.ev = ev; r.er = er; r.ec = ec; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each rising outValid pops one expected vector.
    always @(negedge clk) begin
        if (sb_en && outValid && !ov_q) begin
            if (sb_q.size() == 0) begin
                chk("sb unexpected vector", parallelOut, 32'hxxxxxxxx);
            end else begin
                chk("sb vector", parallelOut, sb_q.pop_front());
            end
        end
        ov_q = outValid;
    end

    initial begin
        logic [31:0] vec;
        logic [7:0]  w;
        int          waited;

        reset = 1'b1; clear = 1'b0; inValid = 1'b0; outAck = 1'b0;
        inData = 8'h00; inIndex = 2'd0;
        s_clear = 1'b0; s_valid = 1'b0; s_ack = 1'b0; s_data = 8'h00;

        // v  data  clr ack | ov rdy cnt parallelOut
        tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 1, 32'h00000011));
        tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 2, 32'h00002211));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 3, 32'h00332211));
        tbl.push_back(mk(1, 8'h44, 0, 0, 1, 0, 0, 32'h44332211));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 8'hFF, 0, 0, 1, 0, 0, 32'h44332211));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h44332211));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 0, 1, 1, 32'h443322A1));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 1, 1, 32'h443322A1));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 0, 1, 2, 32'h4433A2A1));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 1, 2, 32'h4433A2A1));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 0, 1, 3, 32'h44A3A2A1));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 1, 3, 32'h44A3A2A1));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 0, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(1, 8'h77, 0, 1, 0, 1, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 32'hA4A3A2A1));
        tbl.push_back(mk(1, 8'hB1, 0, 0, 0, 1, 1, 32'hA4A3A2B1));
        tbl.push_back(mk(1, 8'hB2, 0, 0, 0, 1, 2, 32'hA4A3B2B1));
        tbl.push_back(mk(1, 8'hB3, 1, 0, 0, 1, 0, 32'hA4A3B2B1));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 0, 1, 1, 32'hA4A3B2C1));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 0, 1, 2, 32'hA4A3C2C1));
        tbl.push_back(mk(1, 8'hC3, 0, 0, 0, 1, 3, 32'hA4C3C2C1));
        tbl.push_back(mk(1, 8'hC4, 0, 0, 1, 0, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 32'hC4C3C2C1));
        tbl.push_back(mk(1, 8'hD1, 0, 0, 0, 1, 1, 32'hC4C3C2D1));

        // Reset for two cycles
        step(); step();
        chk("reset outValid", outValid, 0);
        chk("reset inReady", inReady, 1);
        chk("reset counterOut", counterOut, 0);
        chk("reset parallelOut", parallelOut, 32'h0);
        chk("reset indexError", indexError, 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            inValid = tbl[i].v; inData = tbl[i].d; clear = tbl[i].clr; outAck = tbl[i].ack;
            step();
            chk($sformatf("row%0d outValid", i), outValid, tbl[i].ev);
            chk($sformatf("row%0d inReady", i), inReady, tbl[i].er);
            chk($sformatf("row%0d counterOut", i), counterOut, tbl[i].ec);
            chk($sformatf("row%0d parallelOut", i), parallelOut, tbl[i].ep);
        end
        inValid = 1'b0; clear = 1'b0; outAck = 1'b0;

        // Start the scoreboard from a clean slot 0
        clear = 1'b1; step(); clear = 1'b0;
        sb_en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            vec = '0;
            for (int k = 0; k < 4; k++) begin
                w = 8'($urandom);
                vec[k*8 +: 8] = w;
                if (n % 2 == 1) begin
                    inValid = 1'b0; inData = 8'($urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
                inValid = 1'b1; inData = w;
                if (k == 3) sb_q.push_back(vec);
                step();
            end
            inValid = 1'b0;
            chk($sformatf("vec%0d full after last accept", n), outValid, 1);
            waited = 0;
            while (!outValid && waited < 10) begin
                step(); waited++;
            end
            chk($sformatf("vec%0d outValid bound", n), outValid, 1);
            inValid = 1'b1; inData = 8'hEE;
            repeat ($urandom_range(0, 3)) step();
            chk($sformatf("vec%0d held", n), parallelOut, vec);
            outAck = 1'b1; step(); outAck = 1'b0; inValid = 1'b0;
            chk($sformatf("vec%0d acked", n), outValid, 0);
        end
        @(negedge clk);
        sb_en = 1'b0;
        chk("sb drained", sb_q.size(), 0);

        // Reset mid-vector drops all partial state
        inValid = 1'b1; inData = 8'h12; step();
        inData = 8'h34; step();
        reset = 1'b1; inData = 8'h56; step();
        reset = 1'b0; inValid = 1'b0;
        chk("midreset counterOut", counterOut, 0);
        chk("midreset outValid", outValid, 0);
        chk("midreset inReady", inReady, 1);
        chk("midreset parallelOut", parallelOut, 32'h0);

`ifdef DESER_INDEX_CHECK_EN
        begin
            logic [1:0] idx [4];
            logic       eerr [4];
            idx[0] = 2'd0; idx[1] = 2'd1; idx[2] = 2'd3; idx[3] = 2'd3;
            eerr[0] = 1'b0; eerr[1] = 1'b0; eerr[2] = 1'b1; eerr[3] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                inValid = 1'b1; inData = 8'(8'h60 + k); inIndex = idx[k];
                step();
                chk($sformatf("idx accept%0d indexError", k), indexError, eerr[k]);
            end
            inValid = 1'b0;
            chk("idx word3 written at slot", parallelOut, 32'h63626160);
            chk("idx fsm full", outValid, 1);
            step(); step();
            chk("idx sticky in FULL", indexError, 1);
            clear = 1'b1; step(); clear = 1'b0;
            chk("idx cleared", indexError, 0);
            chk("idx clear outValid", outValid, 0);
        end
`endif

        // Single-word vector instance
        s_valid = 1'b1; s_data = 8'h5A; step();
        chk("n1 outValid", s_ovalid, 1);
        chk("n1 inReady", s_ready, 0);
        chk("n1 counterOut", s_cnt, 0);
        chk("n1 parallelOut", s_par, 8'h5A);
        s_data = 8'hBB; s_ack = 1'b1; step(); s_ack = 1'b0;
        chk("n1 ack drops word", s_par, 8'h5A);
        chk("n1 ack outValid", s_ovalid, 0);
        step();
        chk("n1 second vector", s_par, 8'hBB);
        chk("n1 second outValid", s_ovalid, 1);
        chk("n1 indexError", s_err, 0);
        s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
